mips_run_ctrl: RTL and testbench

MIPS_RUN_CTRL -- requirements
Module: mips_run_ctrl

---
 rtl/mips_run_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: run/stop controller that gates the clock enable of a MIPS core.
// A run is started from IDLE, counts enabled core cycles, and ends on a retired
// halt instruction or when the cycle budget MAX_CYCLES is used up.
// Build option: define MIPS_RUN_CTRL_STEP_EN to add single-step mode
// (step_mode/step inputs with the STEP_WAIT/STEP_EXEC states).
// Without it, step_mode and step are ignored and start always enters RUN.
module mips_run_ctrl #(
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 25
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             clear,
    input  logic             step_mode,
    input  logic             step,
    output logic             core_en,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RUN       = 3'd1,
        S_DONE      = 3'd2
`ifdef MIPS_RUN_CTRL_STEP_EN
        ,
        S_STEP_WAIT = 3'd3,
        S_STEP_EXEC = 3'd4
`endif
    } state_t;

    state_t           state_reg, state_next;
    logic             core_en_next;
    logic             running_next;
    logic             done_next;
    logic             timeout_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] count_plus;
    logic             budget_hit;

`ifdef MIPS_RUN_CTRL_STEP_EN
    logic step_prev_reg;
    logic step_rise;

    // Registered copy of step for 0->1 detection; a held step gives one grant only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_prev_reg <= 1'b0;
        end else begin
            step_prev_reg <= step;
        end
    end

    assign step_rise = step & ~step_prev_reg;
`else
    // Step inputs have no function in this build.
    logic unused_step_inputs;
    assign unused_step_inputs = step_mode | step;
`endif

    // The budget is exhausted when this enabled cycle brings the count to MAX.
    assign count_plus = cycle_count + 1'b1;
    assign budget_hit = core_en && (count_plus == MAX_CNT);

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_next   = state_reg;
        timeout_next = timeout;
        count_next   = cycle_count;

        // Every edge with the core enabled is one executed core cycle.
        if (core_en && (cycle_count != MAX_CNT)) begin
            count_next = count_plus;
        end

        case (state_reg)
            S_IDLE: begin
                count_next   = '0;
                timeout_next = 1'b0;
                if (start) begin
`ifdef MIPS_RUN_CTRL_STEP_EN
                    state_next = step_mode ? S_STEP_WAIT : S_RUN;
`else
                    state_next = S_RUN;
`endif
                end
            end
            S_RUN: begin
                // A retired halt takes priority over budget exhaustion.
                if (halt_req) begin
                    state_next   = S_DONE;
                    timeout_next = 1'b0;
                end else if (budget_hit) begin
                    state_next   = S_DONE;
                    timeout_next = 1'b1;
                end
            end
`ifdef MIPS_RUN_CTRL_STEP_EN
            S_STEP_WAIT: begin
                if (step_rise) begin
                    state_next = S_STEP_EXEC;
                end
            end
            S_STEP_EXEC: begin
                if (halt_req) begin
                    state_next   = S_DONE;
                    timeout_next = 1'b0;
                end else if (budget_hit) begin
                    state_next   = S_DONE;
                    timeout_next = 1'b1;
                end else begin
                    state_next = S_STEP_WAIT;
                end
            end
`endif
            S_DONE: begin
                if (clear) begin
                    state_next   = S_IDLE;
                    count_next   = '0;
                    timeout_next = 1'b0;
                end
            end
            default: begin
                state_next   = S_IDLE;
                count_next   = '0;
                timeout_next = 1'b0;
            end
        endcase

        // Outputs are decoded from the next state so they change with the state.
        core_en_next = (state_next == S_RUN);
        running_next = (state_next == S_RUN);
`ifdef MIPS_RUN_CTRL_STEP_EN
        if (state_next == S_STEP_EXEC) begin
            core_en_next = 1'b1;
        end
        if ((state_next == S_STEP_WAIT) || (state_next == S_STEP_EXEC)) begin
            running_next = 1'b1;
        end
`endif
        done_next = (state_next == S_DONE);
    end

    // State, counter and output registers; reset forces a quiet IDLE at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            core_en     <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            state_reg   <= state_next;
            core_en     <= core_en_next;
            running     <= running_next;
            done        <= done_next;
            timeout     <= timeout_next;
            cycle_count <= count_next;
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Testbench for mips_run_ctrl: directed runs; each expected run result is queued
// when the run is started and checked by a monitor when done rises.
module tb_mips_run_ctrl;

    localparam int CNT_W      = 16;
    localparam int MAX_CYCLES = 25;

    logic             clock = 1'b0;
    logic             reset_n = 1'b1;
    logic             start = 1'b0;
    logic             halt_req = 1'b0;
    logic             clear = 1'b0;
    logic             step_mode = 1'b0;
    logic             step = 1'b0;
    logic             core_en;
    logic             running;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    typedef struct {
        int timeout;
        int count;
        int en_cycles;
        int pulses;
        int max_len;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    mips_run_ctrl #(
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAX_CYCLES)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .halt_req    (halt_req),
        .clear       (clear),
        .step_mode   (step_mode),
        .step        (step),
        .core_en     (core_en),
        .running     (running),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input int t, input int c, input int en, input int p, input int ml);
        exp_t e;
        e.timeout = t; e.count = c; e.en_cycles = en; e.pulses = p; e.max_len = ml;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check(name, int'(done), 1);
    endtask

    task automatic wait_count(input string name, input int target);
        int n = 0;
        while (int'(cycle_count) != target && n < 200) begin
            tick();
            n++;
        end
        check(name, int'(cycle_count), target);
    endtask

    task automatic do_clear(input string name);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check({name, "_done"}, int'(done), 0);
        check({name, "_count"}, int'(cycle_count), 0);
        check({name, "_timeout"}, int'(timeout), 0);
        check({name, "_running"}, int'(running), 0);
    endtask

    // Monitor: measures core_en activity per run, compares at each rising done.
    initial begin
        int en_cnt = 0;
        int pulses = 0;
        int cur_len = 0;
        int max_len = 0;
        bit done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                en_cnt = 0; pulses = 0; cur_len = 0; max_len = 0; done_prev = 1'b0;
            end else begin
                if (core_en) begin
                    if (cur_len == 0) pulses++;
                    cur_len++;
                    en_cnt++;
                    if (cur_len > max_len) max_len = cur_len;
                end else begin
                    cur_len = 0;
                end
                if (done && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1, expected no run end");
                    end else begin
                        e = exp_q.pop_front();
                        check("run_timeout", int'(timeout), e.timeout);
                        check("run_count", int'(cycle_count), e.count);
                        check("run_en_cycles", en_cnt, e.en_cycles);
                        check("run_pulses", pulses, e.pulses);
                        check("run_max_pulse", max_len, e.max_len);
                    end
                    $display("[TB] run end: timeout=%0d count=%0d en_cycles=%0d pulses=%0d max_pulse=%0d",
                             timeout, cycle_count, en_cnt, pulses, max_len);
                    en_cnt = 0; pulses = 0; cur_len = 0; max_len = 0;
                end
                done_prev = done;
            end
        end
    end

    initial begin
        // Reset state
        #1 reset_n = 1'b0;
        #1;
        check("rst_core_en", int'(core_en), 0);
        check("rst_running", int'(running), 0);
        check("rst_done", int'(done), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_count", int'(cycle_count), 0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check("idle_no_start", int'(running), 0);

        // Free run to budget exhaustion
        push_exp(1, 25, 25, 1, 25);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_core_en", int'(core_en), 1);
        check("start_running", int'(running), 1);
        check("start_count", int'(cycle_count), 0);
        wait_done("budget_done");
        check("budget_timeout", int'(timeout), 1);
        tick();
        tick();
        check("budget_hold", int'(cycle_count), 25);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_ignores_start", int'(done), 1);
        check("done_core_en", int'(core_en), 0);
        do_clear("clr1");

        // Halt after 10 enabled cycles
        push_exp(0, 10, 10, 1, 10);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_count("halt10_reach", 9);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("halt10_done", int'(done), 1);
        check("halt10_timeout", int'(timeout), 0);
        check("halt10_count", int'(cycle_count), 10);
        tick();
        do_clear("clr2");

        // Halt on the same edge as budget exhaustion
        push_exp(0, 25, 25, 1, 25);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_count("tie_reach", 24);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("tie_done", int'(done), 1);
        check("tie_timeout", int'(timeout), 0);
        tick();
        do_clear("clr3");

`ifdef MIPS_RUN_CTRL_STEP_EN
        // Single-step: three grants (one held high 5 cycles), then a halting step
        push_exp(0, 4, 4, 4, 1);
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        step_mode = 1'b0;
        check("step_wait_running", int'(running), 1);
        check("step_wait_core_en", int'(core_en), 0);
        tick();
        check("step_wait_idle", int'(core_en), 0);
        step = 1'b1;
        tick();
        check("step1_core_en", int'(core_en), 1);
        step = 1'b0;
        tick();
        check("step1_count", int'(cycle_count), 1);
        step = 1'b1;
        tick();
        check("step2_core_en", int'(core_en), 1);
        tick();
        tick();
        tick();
        tick();
        check("step2_held_core_en", int'(core_en), 0);
        check("step2_count", int'(cycle_count), 2);
        step = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        check("step3_count", int'(cycle_count), 3);
        check("step3_core_en", int'(core_en), 0);
        step = 1'b1;
        halt_req = 1'b1;
        tick();
        tick();
        step = 1'b0;
        halt_req = 1'b0;
        check("step_halt_done", int'(done), 1);
        check("step_halt_timeout", int'(timeout), 0);
        tick();
        do_clear("clr4");
`else
        // Without the step build, step_mode is ignored and start enters RUN
        push_exp(1, 25, 25, 1, 25);
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        step_mode = 1'b0;
        check("nostep_core_en", int'(core_en), 1);
        check("nostep_running", int'(running), 1);
        wait_done("nostep_done");
        tick();
        do_clear("clr4");
`endif

        // Asynchronous reset in the middle of a run
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_count("rst_mid_reach", 7);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_core_en", int'(core_en), 0);
        check("rst_mid_running", int'(running), 0);
        check("rst_mid_done", int'(done), 0);
        check("rst_mid_timeout", int'(timeout), 0);
        check("rst_mid_count", int'(cycle_count), 0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_core_en", int'(core_en), 0);
        end
        check("post_rst_count", int'(cycle_count), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
